// File: rtl/alarma_pkg.sv
// Shared types and constants for the alarm buzzer driver: FSM state encoding,
// default timing parameters and width helpers.
package alarma_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ESPERA   = 3'd1,
    PITA_ON  = 3'd2,
    PITA_OFF = 3'd3,
    SILENCIO = 3'd4
  } estado_t;

  localparam int DELAY_CYC_DEF = 8;
  localparam int ON_CYC_DEF    = 4;
  localparam int OFF_CYC_DEF   = 4;
  localparam int MAX_BEEPS_DEF = 6;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // A single-valued range still needs one bit of counter.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/contador_ciclos.sv
// Cycle counter with synchronous clear and a terminal-count compare flag.
module contador_ciclos #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         fin
);

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

  assign fin = (cnt == term);

endmodule

// File: rtl/alarma_zumbador.sv
// Buzzer driver: grace delay on sAlr, bounded on/off beep pattern, silent lockout.
// Optional feature: define ALARMA_ACK_EN to let ack silence an active beep pattern.
module alarma_zumbador
  import alarma_pkg::*;
#(
  parameter int DELAY_CYC = DELAY_CYC_DEF,
  parameter int ON_CYC    = ON_CYC_DEF,
  parameter int OFF_CYC   = OFF_CYC_DEF,
  parameter int MAX_BEEPS = MAX_BEEPS_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sAlr,
  input  logic                           ack,
  output logic                           zumbador,
  output logic                           activa,
  output logic [$clog2(MAX_BEEPS+1)-1:0] cuenta_pitidos
);

  localparam int CW = cnt_width(max3(DELAY_CYC, ON_CYC, OFF_CYC));
  localparam int BW = $clog2(MAX_BEEPS + 1);

  estado_t       state;
  estado_t       state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] term;
  logic          fin;
  logic          clr;
  logic          ack_eff;
  logic [BW-1:0] cuenta_next;

`ifdef ALARMA_ACK_EN
  assign ack_eff = ack;
`else
  logic unused_ack;
  assign unused_ack = ack;
  assign ack_eff    = 1'b0;
`endif

  always_comb begin
    term = '0;
    case (state)
      ESPERA:   term = CW'(DELAY_CYC - 1);
      PITA_ON:  term = CW'(ON_CYC - 1);
      PITA_OFF: term = CW'(OFF_CYC - 1);
      default:  term = '0;
    endcase
  end

  // The counter restarts whenever the state is about to change.
  assign clr = (state_next != state);

  contador_ciclos #(.W(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .term  (term),
    .cnt   (cnt),
    .fin   (fin)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:
        if (sAlr) state_next = ESPERA;
      ESPERA:
        if (!sAlr)    state_next = IDLE;
        else if (fin) state_next = PITA_ON;
      PITA_ON:
        if (!sAlr)        state_next = IDLE;
        else if (ack_eff) state_next = SILENCIO;
        else if (fin)     state_next = PITA_OFF;
      PITA_OFF:
        if (!sAlr)        state_next = IDLE;
        else if (ack_eff) state_next = SILENCIO;
        else if (fin)
          state_next = (cuenta_pitidos == BW'(MAX_BEEPS)) ? SILENCIO : PITA_ON;
      SILENCIO:
        if (!sAlr) state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  always_comb begin
    cuenta_next = cuenta_pitidos;
    if (state_next == IDLE)
      cuenta_next = '0;
    else if (state_next == PITA_ON && state != PITA_ON && cuenta_pitidos != BW'(MAX_BEEPS))
      cuenta_next = cuenta_pitidos + BW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      zumbador       <= 1'b0;
      activa         <= 1'b0;
      cuenta_pitidos <= '0;
    end else begin
      state          <= state_next;
      zumbador       <= (state_next == PITA_ON);
      activa         <= (state_next != IDLE);
      cuenta_pitidos <= cuenta_next;
    end
  end

endmodule

// File: tb/tb_alarma_zumbador.sv
// Directed scoreboard bench for alarma_zumbador with default parameters.
module tb_alarma_zumbador;

  localparam int D   = 8;
  localparam int ON  = 4;
  localparam int OFF = 4;
  localparam int MB  = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sAlr = 1'b0;
  logic       ack = 1'b0;
  logic       zumbador;
  logic       activa;
  logic [2:0] cuenta_pitidos;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];
  string      tag_q[$];

  alarma_zumbador dut (
    .clk            (clk),
    .reset          (reset),
    .sAlr           (sAlr),
    .ack            (ack),
    .zumbador       (zumbador),
    .activa         (activa),
    .cuenta_pitidos (cuenta_pitidos)
  );

  always #5 clk = ~clk;

  // Expected {zumbador, activa, cuenta} k edges after ESPERA entry, sAlr held high.
  function automatic logic [4:0] episode(input int k);
    int j, b;
    if (k < D) return {1'b0, 1'b1, 3'd0};
    j = k - D;
    b = j / (ON + OFF);
    if (b >= MB) return {1'b0, 1'b1, 3'(MB)};
    return {((j % (ON + OFF)) < ON), 1'b1, 3'(b + 1)};
  endfunction

  task automatic tick(input logic [4:0] expv, input string tag);
    logic [4:0] obs, want;
    string t;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    obs  = {zumbador, activa, cuenta_pitidos};
    checks++;
    $display("%s t=%0t rst=%b s=%b ack=%b -> z=%b act=%b cnt=%0d", t, $time,
             reset, sAlr, ack, obs[4], obs[3], obs[2:0]);
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed z/act/cnt=%b/%b/%0d expected %b/%b/%0d", t,
             obs[4], obs[3], obs[2:0], want[4], want[3], want[2:0]);
    end
  endtask

  initial begin
    // Reset with sAlr high: everything stays quiet.
    @(negedge clk);
    reset = 1'b1; sAlr = 1'b1; ack = 1'b0;
    tick(5'b0_0_000, "reset0");
    tick(5'b0_0_000, "reset1");
    reset = 1'b0;
    tick(episode(0), "rel_espera");

    // Glitch: five cycles in ESPERA, then sAlr drops.
    for (int k = 1; k < 5; k++) tick(episode(k), "glitch_hi");
    sAlr = 1'b0;
    tick(5'b0_0_000, "glitch_idle");
    tick(5'b0_0_000, "glitch_idle2");

    // Full episode with sAlr held.
    sAlr = 1'b1;
    for (int k = 0; k < 60; k++) tick(episode(k), "full_ep");
    sAlr = 1'b0;
    tick(5'b0_0_000, "full_drop");

    // Acknowledge during the second beep.
    sAlr = 1'b1;
    for (int k = 0; k <= 16; k++) tick(episode(k), "ack_pre");
    ack = 1'b1;
`ifdef ALARMA_ACK_EN
    tick(5'b0_1_010, "ack_hit");
`else
    tick(episode(17), "ack_hit");
`endif
    ack = 1'b0;
    for (int k = 18; k < 60; k++) begin
`ifdef ALARMA_ACK_EN
      tick(5'b0_1_010, "ack_post");
`else
      tick(episode(k), "ack_post");
`endif
    end
    sAlr = 1'b0;
    tick(5'b0_0_000, "ack_drop");

    // sAlr low and ack high together in PITA_OFF: sAlr wins.
    sAlr = 1'b1;
    for (int k = 0; k <= 12; k++) tick(episode(k), "simul_pre");
    sAlr = 1'b0; ack = 1'b1;
    tick(5'b0_0_000, "simul_idle");
    ack = 1'b0;
    tick(5'b0_0_000, "simul_idle2");

    // Reset in the third beep; ack during ESPERA is ignored.
    sAlr = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      ack = (k >= 2 && k <= 4);
      tick(episode(k), "rst_pre");
    end
    ack = 1'b0;
    reset = 1'b1;
    tick(5'b0_0_000, "rst_mid");
    reset = 1'b0;
    for (int k = 0; k <= 12; k++) tick(episode(k), "rst_restart");
    sAlr = 1'b0;
    tick(5'b0_0_000, "final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarma_zumbador.md
# alarma_zumbador

Sequential buzzer driver that sits directly downstream of the combinational car-alarm detector and consumes its `sAlr` output. It requires `sAlr` to stay asserted for a grace period, then drives a periodic on/off beep pattern on `zumbador`. The pattern stops after a bounded number of beeps, when the user acknowledges, or when `sAlr` drops. A silent lockout prevents re-triggering until `sAlr` has cleared.

## Interface
Parameters:
- `DELAY_CYC`, 8: consecutive cycles `sAlr` must be sampled high before the first beep (≥1).
- `ON_CYC`, 4: cycles `zumbador` is high per beep (≥1).
- `OFF_CYC`, 4: cycles `zumbador` is low between beeps (≥1).
- `MAX_BEEPS`, 6: beeps per alarm episode before lockout (≥1).

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `sAlr`, in, 1: alarm condition from the upstream detector; assumed synchronous to `clk`.
- `ack`, in, 1: user acknowledge/silence, level-sampled.
- `zumbador`, out, 1: buzzer drive.
- `activa`, out, 1: high in every state except IDLE.
- `cuenta_pitidos`, out, `$clog2(MAX_BEEPS+1)`: number of beeps started in the current episode.

## Operation
- There are five FSM states: IDLE, ESPERA, PITA_ON, PITA_OFF, SILENCIO.
- One cycle counter `cnt` has width `$clog2(max(DELAY_CYC,ON_CYC,OFF_CYC))` (minimum 1). It clears on every state change and increments otherwise.
- **IDLE**
  - `sAlr`=1 → ESPERA.
  - `cuenta_pitidos` is held at 0.
- **ESPERA**
  - `sAlr`=0 → IDLE.
  - `cnt`==DELAY_CYC-1 with `sAlr`=1 → PITA_ON.
- **PITA_ON**
  - `cnt`==ON_CYC-1 → PITA_OFF.
- **PITA_OFF**
  - `cnt`==OFF_CYC-1 → SILENCIO if `cuenta_pitidos`==MAX_BEEPS, else PITA_ON.
- **SILENCIO**
  - `sAlr`=0 → IDLE.
  - Otherwise the FSM holds.
- **Priority in PITA_ON and PITA_OFF:** `sAlr`=0 → IDLE; else `ack`=1 → SILENCIO; else the timed transition above.
- `ack` is ignored in IDLE, ESPERA and SILENCIO.
- `cuenta_pitidos` increments on every entry into PITA_ON and saturates at MAX_BEEPS. It holds its value in PITA_OFF and SILENCIO, and clears on entry into IDLE.
- Outputs are Moore-decoded from registered state: `zumbador` = (state==PITA_ON); `activa` = (state!=IDLE).

## Timing
- Reset: state=IDLE, `cnt`=0, `zumbador`=0, `activa`=0, `cuenta_pitidos`=0, all valid from the edge after `reset` is sampled high.
- Reset overrides every other input, including mid-beep.
- If `sAlr` is first sampled high at edge n:
  - `activa`=1 from edge n.
  - `zumbador`=1 from edge n+DELAY_CYC.
- Each beep is high for exactly ON_CYC cycles and low for OFF_CYC cycles.
- Full episode: ESPERA→SILENCIO spans DELAY_CYC + MAX_BEEPS·(ON_CYC+OFF_CYC) cycles.
- `sAlr` low or `ack` high during a beep drives `zumbador` to 0 at the next edge; no partial-beep extension.
- Single-cycle `sAlr` glitch in ESPERA → IDLE; no beep, `cuenta_pitidos` stays 0.
- `sAlr`=0 in SILENCIO → IDLE in one cycle. A new episode needs a fresh full DELAY_CYC.

## Configuration
- Macro `ALARMA_ACK_EN`:
  - Defined: `ack` behaves as described above.
  - Undefined: the `ack` port remains but is ignored internally, so only MAX_BEEPS or `sAlr`=0 end the beeping.
- The port list is identical in both builds.

## Structure
- Package `alarma_pkg`: state encoding (IDLE=0, ESPERA=1, PITA_ON=2, PITA_OFF=3, SILENCIO=4, 3-bit) and default parameter constants.
- Sub-module `contador_ciclos`: synchronous clear/increment counter with a terminal-count compare input. It is instanced once for `cnt`.

## Test plan
- **Reset, then idle:** assert `reset` for 2 cycles with `sAlr`=1 → all outputs 0 throughout; after release, ESPERA is entered on the first sampled edge.
- **Glitch:** `sAlr` high for 5 cycles, then low → `activa` high for 5 cycles, `zumbador` never high, back to IDLE, `cuenta_pitidos`=0.
- **Full episode** (defaults), `sAlr` held high:
  - `zumbador` high at cycles 8–11, 16–19, …, 48–51.
  - `cuenta_pitidos` reaches 6.
  - SILENCIO from cycle 56 with `activa`=1; dropping `sAlr` → IDLE the next cycle.
- **Acknowledge** (with `ALARMA_ACK_EN`): `ack` pulse in the second PITA_ON → `zumbador`=0 next edge, SILENCIO, `cuenta_pitidos`=2. Without the macro, the same stimulus still yields 6 beeps.
- **Simultaneous events:** `sAlr`=0 and `ack`=1 in the same PITA_OFF cycle → IDLE (not SILENCIO), `cuenta_pitidos`=0.
- **Reset mid-beep:** `reset` in the third PITA_ON → `zumbador`, `activa` and `cuenta_pitidos` all 0 next edge; a new episode restarts with the full 8-cycle delay.
